// File: rtl/psum_drain_deskew_if.sv
// Psum drain bus: skewed column input, tile control and aligned FIFO output.
// master drives in_valid/col_psum/tile_rows/out_ready; slave drives the rest.
interface psum_drain_deskew_if #(
  parameter int N      = 8,
  parameter int PSUM_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  in_valid;
  logic [N*PSUM_W-1:0]   col_psum;
  logic [7:0]            tile_rows;
  logic [N*PSUM_W-1:0]   out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CW-1:0]         fifo_count;
  logic                  tile_done;
  logic                  overflow;

  modport master (
    output in_valid, col_psum, tile_rows, out_ready,
    input  out_data, out_valid, fifo_count, tile_done, overflow
  );

  modport slave (
    input  in_valid, col_psum, tile_rows, out_ready,
    output out_data, out_valid, fifo_count, tile_done, overflow
  );
endinterface

// File: rtl/psum_drain_deskew.sv
// Deskews the bottom-row psums of a systolic array into aligned rows,
// buffers them in a small FIFO and counts rows per tile.
// Ports: clk, rst (async, active-high), clear (sync flush), bus (slave):
//   in_valid/col_psum/tile_rows in; out_data/out_valid/out_ready FIFO head;
//   fifo_count, tile_done pulse, sticky overflow.
module psum_drain_deskew #(
  parameter int N      = 8,
  parameter int PSUM_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  psum_drain_deskew_if.slave   bus
);
  localparam int W  = PSUM_W;
  localparam int RW = N * W;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [N-2:0]  vld_q, vld_d;
  logic          wr_valid;
  logic [RW-1:0] row;

  // Column j arrives j cycles after column 0, so it needs N-1-j stages.
  for (genvar j = 0; j < N; j++) begin : g_col
    localparam int L = N - 1 - j;
    if (L == 0) begin : g_pass
      assign row[j*W +: W] = bus.col_psum[j*W +: W];
    end else begin : g_dly
      logic [W-1:0] d_q [L];
      logic [W-1:0] d_d [L];

      always_comb begin
        d_d[0] = bus.col_psum[j*W +: W];
        for (int k = 1; k < L; k++) d_d[k] = d_q[k-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < L; k++) d_q[k] <= '0;
        end else begin
          d_q <= d_d;
        end
      end

      assign row[j*W +: W] = d_q[L-1];
    end
  end

  always_comb begin
    vld_d[0] = bus.in_valid;
    for (int k = 1; k < N - 1; k++) vld_d[k] = vld_q[k-1];
    if (clear) vld_d = '0;
  end

  assign wr_valid = vld_q[N-2];

  logic [RW-1:0] mem_q [DEPTH];
  logic [RW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    rc_q, rc_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          full, pop, push;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full   = (cnt_q == CW'(DEPTH));
    pop    = (cnt_q != '0) & bus.out_ready & ~clear;
    // A full FIFO still accepts the row when the head leaves this cycle.
    push   = wr_valid & ~clear & (~full | pop);
    mem_d  = mem_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    cnt_d  = cnt_q;
    rc_d   = rc_q;
    done_d = 1'b0;
    ovf_d  = ovf_q;
    if (clear) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
      rc_d  = '0;
      ovf_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wp_q] = row;
        wp_d        = inc(wp_q);
      end
      if (pop) rp_d = inc(rp_q);
      if (push && !pop) cnt_d = cnt_q + 1'b1;
      if (pop && !push) cnt_d = cnt_q - 1'b1;
      if (wr_valid && full && !pop) ovf_d = 1'b1;
      // tile_rows of 0 wraps to 255 here, giving 256-row tiles.
      if (wr_valid) begin
        if (rc_q == bus.tile_rows - 8'd1) begin
          rc_d   = '0;
          done_d = 1'b1;
        end else begin
          rc_d = rc_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      rc_q   <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      mem_q  <= mem_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      rc_q   <= rc_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.out_data   = mem_q[rp_q];
  assign bus.out_valid  = (cnt_q != '0);
  assign bus.fifo_count = cnt_q;
  assign bus.tile_done  = done_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_psum_drain_deskew.sv
// Bench for psum_drain_deskew: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_psum_drain_deskew;
  localparam int N     = 8;
  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int RW    = N * W;

  typedef logic [RW-1:0] row_t;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  psum_drain_deskew_if #(.N(N), .PSUM_W(W), .DEPTH(DEPTH)) bus ();

  psum_drain_deskew #(.N(N), .PSUM_W(W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int ov_cnt   = 0;
  int max_cnt  = 0;

  task automatic chk(string name, row_t act, row_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: history of inputs per cycle; an aligned row is
  // assembled from column j of cycle s+j once cycle s+N-1 is reached.
  logic hv [16];
  row_t hd [16];
  row_t m_q [$];
  int   m_cyc = 0;
  int   m_lastclr = -1;
  int   m_rc = 0;
  bit   m_done = 0;
  bit   m_ovf = 0;
  int   ms;
  bit   mwv;
  bit   mpop;
  row_t mrow;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_cyc = 0;
      m_lastclr = -1;
      m_rc = 0;
      m_done = 0;
      m_ovf = 0;
      for (int i = 0; i < 16; i++) begin
        hv[i] = 1'b0;
        hd[i] = '0;
      end
    end else begin
      hv[m_cyc % 16] = bus.in_valid;
      hd[m_cyc % 16] = bus.col_psum;
      ms  = m_cyc - (N - 1);
      mwv = (ms >= 0) && (ms > m_lastclr) && hv[ms % 16];
      mrow = '0;
      if (mwv)
        for (int j = 0; j < N; j++)
          mrow[j*W +: W] = hd[(ms + j) % 16][j*W +: W];
      mpop = (m_q.size() != 0) && bus.out_ready;
      if (clr) begin
        m_q.delete();
        m_rc = 0;
        m_done = 0;
        m_ovf = 0;
        m_lastclr = m_cyc;
      end else begin
        m_done = 0;
        if (mpop) void'(m_q.pop_front());
        if (mwv) begin
          if (m_q.size() < DEPTH) m_q.push_back(mrow);
          else m_ovf = 1;
          if (m_rc == (int'(bus.tile_rows) + 255) % 256) begin
            m_rc = 0;
            m_done = 1;
          end else begin
            m_rc++;
          end
        end
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", row_t'(bus.out_valid), row_t'(0));
      chk("rst_fifo_count", row_t'(bus.fifo_count), row_t'(0));
      chk("rst_out_data", bus.out_data, row_t'(0));
    end else begin
      chk("out_valid", row_t'(bus.out_valid), row_t'(m_q.size() != 0));
      chk("fifo_count", row_t'(bus.fifo_count), row_t'(m_q.size()));
      chk("tile_done", row_t'(bus.tile_done), row_t'(m_done));
      chk("overflow", row_t'(bus.overflow), row_t'(m_ovf));
      if (m_q.size() != 0) chk("out_data", bus.out_data, m_q[0]);
      if (bus.tile_done) done_cnt++;
      if (bus.out_valid) ov_cnt++;
      if (int'(bus.fifo_count) > max_cnt) max_cnt = int'(bus.fifo_count);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Drives nrows back-to-back rows with the array's skew; row r column j
  // carries base + r*16 + j. Unused columns carry junk.
  task automatic stream(int nrows, logic [31:0] base, int rdy_c, int clr_c);
    int r;
    for (int c = 0; c < nrows + N - 1; c++) begin
      bus.in_valid = (c < nrows);
      clr = (c == clr_c);
      if (rdy_c >= 0) bus.out_ready = (c == rdy_c);
      for (int j = 0; j < N; j++) begin
        r = c - j;
        if (r >= 0 && r < nrows)
          bus.col_psum[j*W +: W] = base + 32'(r * 16) + 32'(j);
        else
          bus.col_psum[j*W +: W] = 32'hBAD0_0000 + 32'(c * 16) + 32'(j);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    clr = 1'b0;
    if (rdy_c >= 0) bus.out_ready = 1'b0;
  endtask

  row_t        exp_row;
  logic [31:0] last;

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    bus.in_valid  = 1'b0;
    bus.col_psum  = '0;
    bus.tile_rows = 8'd8;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Rows in flight at reset must never appear.
    bus.in_valid = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    ov_cnt = 0;
    repeat (2 * N) tick();
    chk("rst_midstream_rows", row_t'(ov_cnt), row_t'(0));

    // Single row, column j = 100+j in cycle t+j.
    exp_row = '0;
    for (int j = 0; j < N; j++) exp_row[j*W +: W] = 32'(100 + j);
    for (int i = 0; i < N; i++) begin
      bus.in_valid = (i == 0);
      for (int j = 0; j < N; j++)
        bus.col_psum[j*W +: W] = (j == i) ? 32'(100 + i) : 32'hEEEE_0000 + 32'(j);
      if (i == N - 1) chk("t1_not_early", row_t'(bus.out_valid), row_t'(0));
      tick();
    end
    bus.in_valid = 1'b0;
    chk("t1_out_valid", row_t'(bus.out_valid), row_t'(1));
    chk("t1_out_data", bus.out_data, exp_row);
    chk("t1_count1", row_t'(bus.fifo_count), row_t'(1));
    bus.out_ready = 1'b1;
    tick();
    chk("t1_count0", row_t'(bus.fifo_count), row_t'(0));

    // 8 back-to-back rows drained as they arrive.
    do_clear();
    bus.tile_rows = 8'd8;
    bus.out_ready = 1'b1;
    done_cnt = 0;
    ov_cnt = 0;
    max_cnt = 0;
    stream(8, 32'h1000_0000, -1, -1);
    repeat (3) tick();
    chk("t2_valid_cycles", row_t'(ov_cnt), row_t'(8));
    chk("t2_done_pulses", row_t'(done_cnt), row_t'(1));
    chk("t2_max_count", row_t'(max_cnt <= 1), row_t'(1));

    // Overflow with no consumer.
    do_clear();
    bus.out_ready = 1'b0;
    stream(6, 32'h2000_0000, -1, -1);
    repeat (2) tick();
    chk("t3_count_full", row_t'(bus.fifo_count), row_t'(4));
    chk("t3_overflow", row_t'(bus.overflow), row_t'(1));
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_pop_row", row_t'(bus.out_data[W-1:0]), row_t'(32'h2000_0000 + 32'(k * 16)));
      tick();
    end
    chk("t3_empty", row_t'(bus.fifo_count), row_t'(0));
    chk("t3_ovf_sticky", row_t'(bus.overflow), row_t'(1));

    // Full FIFO, push and pop in the same edge.
    do_clear();
    bus.out_ready = 1'b0;
    stream(4, 32'h3000_0000, -1, -1);
    tick();
    chk("t4_full", row_t'(bus.fifo_count), row_t'(4));
    stream(1, 32'h3800_0000, N - 1, -1);
    chk("t4_count_kept", row_t'(bus.fifo_count), row_t'(4));
    chk("t4_no_overflow", row_t'(bus.overflow), row_t'(0));
    bus.out_ready = 1'b1;
    last = '0;
    for (int k = 0; k < 4; k++) begin
      last = bus.out_data[W-1:0];
      tick();
    end
    chk("t4_last_popped", row_t'(last), row_t'(32'h3800_0000));
    chk("t4_empty", row_t'(bus.fifo_count), row_t'(0));

    // clear with 2 rows stored and 3 in the delay line.
    do_clear();
    bus.out_ready = 1'b0;
    stream(5, 32'h4000_0000, -1, N + 1);
    chk("t5_count", row_t'(bus.fifo_count), row_t'(0));
    chk("t5_out_valid", row_t'(bus.out_valid), row_t'(0));
    chk("t5_overflow", row_t'(bus.overflow), row_t'(0));
    ov_cnt = 0;
    repeat (2 * N) tick();
    chk("t5_no_ghost_rows", row_t'(ov_cnt), row_t'(0));

    // Tile length boundaries.
    do_clear();
    bus.out_ready = 1'b1;
    bus.tile_rows = 8'd0;
    done_cnt = 0;
    stream(256, 32'h5000_0000, -1, -1);
    repeat (3) tick();
    chk("t6_done_256", row_t'(done_cnt), row_t'(1));
    bus.tile_rows = 8'd3;
    done_cnt = 0;
    stream(9, 32'h6000_0000, -1, -1);
    repeat (3) tick();
    chk("t6_done_3", row_t'(done_cnt), row_t'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
